// File: rtl/icache_data_sram_ctrl.sv
// rtl/icache_data_sram_ctrl.sv - single-master controller for the icache data SRAM (refill writes + fetch reads)
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   refill_req_i/refill_line_i/refill_gnt_o
//                                       line refill request, line index, grant (high in IDLE)
//   refill_valid_i/refill_data_i/refill_ready_o
//                                       refill beat stream; ready means the SRAM write was issued
//   refill_done_o                       one-cycle pulse after the last beat of a line is written
//   rd_req_i/rd_addr_i/rd_gnt_o         fetch read request, word address, grant (SRAM read issued)
//   rd_rvalid_o/rd_rdata_o/rd_rready_i  read response stream with back-pressure
//   sram_req_o/sram_we_o/sram_addr_o/sram_wdata_o/sram_be_o/sram_rdata_i
//                                       one-port SRAM, read data valid one cycle after request
module icache_data_sram_ctrl #(
  parameter int NumWords  = 512,
  parameter int DataWidth = 128,
  parameter int LineWords = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 refill_req_i,
  input  logic [$clog2(NumWords/LineWords)-1:0] refill_line_i,
  output logic                                 refill_gnt_o,
  input  logic                                 refill_valid_i,
  input  logic [DataWidth-1:0]                 refill_data_i,
  output logic                                 refill_ready_o,
  output logic                                 refill_done_o,
  input  logic                                 rd_req_i,
  input  logic [$clog2(NumWords)-1:0]          rd_addr_i,
  output logic                                 rd_gnt_o,
  output logic                                 rd_rvalid_o,
  output logic [DataWidth-1:0]                 rd_rdata_o,
  input  logic                                 rd_rready_i,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [$clog2(NumWords)-1:0]          sram_addr_o,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  output logic [(DataWidth+7)/8-1:0]           sram_be_o,
  input  logic [DataWidth-1:0]                 sram_rdata_i
);

  localparam int AddrW = $clog2(NumWords);
  localparam int LineW = $clog2(NumWords / LineWords);
  localparam int BeatW = $clog2(LineWords);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StWrite = 1'b1;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(LineWords - 1);

  logic [0:0]           state_q;
  logic [LineW-1:0]     line_q;
  logic [BeatW-1:0]     beat_cnt_q;
  logic                 done_q;
  logic                 inflight_q;
  logic                 held_valid_q;
  logic [DataWidth-1:0] held_data_q;

  logic wr_fire;
  logic hazard;
  logic occ_any;
  logic rd_fire;

  // A refill beat always wins the SRAM port.
  assign wr_fire = (state_q == StWrite) && refill_valid_i;

  // Reads into the line being refilled would see a half-written line.
  assign hazard  = (state_q == StWrite) && (rd_addr_i[AddrW-1:BeatW] == line_q);

  // inflight and held_valid are mutually exclusive, so occ is 0 or 1; a new
  // read may only issue when the single pending response drains this cycle.
  assign occ_any = inflight_q | held_valid_q;
  assign rd_fire = rd_req_i && !wr_fire && !hazard && (!occ_any || rd_rready_i);

  assign refill_gnt_o   = (state_q == StIdle);
  assign refill_ready_o = wr_fire;
  assign refill_done_o  = done_q;
  assign rd_gnt_o       = rd_fire;
  assign rd_rvalid_o    = occ_any;
  assign rd_rdata_o     = held_valid_q ? held_data_q : sram_rdata_i;

  assign sram_req_o   = wr_fire | rd_fire;
  assign sram_we_o    = wr_fire;
  assign sram_addr_o  = wr_fire ? {line_q, beat_cnt_q} : rd_addr_i;
  assign sram_wdata_o = refill_data_i;
  assign sram_be_o    = '1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      line_q     <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (refill_req_i) begin
            line_q     <= refill_line_i;
            beat_cnt_q <= '0;
            state_q    <= StWrite;
          end
        end
        default: begin
          if (refill_valid_i) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LastBeat) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // SRAM output is only valid for one cycle, so a stalled response is parked
  // in the hold register and served from there until consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q   <= 1'b0;
      held_valid_q <= 1'b0;
      held_data_q  <= '0;
    end else begin
      inflight_q <= rd_fire;
      if (inflight_q && !rd_rready_i) begin
        held_valid_q <= 1'b1;
        held_data_q  <= sram_rdata_i;
      end else if (held_valid_q && rd_rready_i) begin
        held_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_icache_data_sram_ctrl.sv
// tb/tb_icache_data_sram_ctrl.sv - scoreboard testbench for icache_data_sram_ctrl
module tb_icache_data_sram_ctrl;

  localparam int NW  = 512;
  localparam int DW  = 128;
  localparam int LW  = 2;
  localparam int AW  = 9;
  localparam int LIW = 8;
  localparam int BEW = 16;

  localparam logic [DW-1:0] D_C = {4{32'h1111_000C}};
  localparam logic [DW-1:0] D_D = {4{32'h2222_000D}};
  localparam logic [DW-1:0] D_E = {4{32'h3333_000E}};
  localparam logic [DW-1:0] D_F = {4{32'h4444_000F}};
  localparam logic [DW-1:0] D_G = {4{32'h5555_0001}};
  localparam logic [DW-1:0] D_H = {4{32'h6666_0002}};
  localparam logic [DW-1:0] D_I = {4{32'h7777_0003}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           refill_req;
  logic [LIW-1:0] refill_line;
  logic           refill_gnt;
  logic           refill_valid;
  logic [DW-1:0]  refill_data;
  logic           refill_ready;
  logic           refill_done;
  logic           rd_req;
  logic [AW-1:0]  rd_addr;
  logic           rd_gnt;
  logic           rd_rvalid;
  logic [DW-1:0]  rd_rdata;
  logic           rd_rready;
  logic           sram_req;
  logic           sram_we;
  logic [AW-1:0]  sram_addr;
  logic [DW-1:0]  sram_wdata;
  logic [BEW-1:0] sram_be;
  logic [DW-1:0]  sram_rdata;

  icache_data_sram_ctrl #(.NumWords(NW), .DataWidth(DW), .LineWords(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .refill_req_i(refill_req), .refill_line_i(refill_line), .refill_gnt_o(refill_gnt),
    .refill_valid_i(refill_valid), .refill_data_i(refill_data), .refill_ready_o(refill_ready),
    .refill_done_o(refill_done),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata), .rd_rready_i(rd_rready),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  logic [DW-1:0] sram_mem [NW];
  logic [DW-1:0] exp_mem  [NW];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] rd_q [$];
  wr_t           wr_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return {4{32'hA5C3_0000 ^ 32'(i)}};
  endfunction

  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BEW; b++)
          if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] = sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Scoreboard monitor: pops on every response handshake and SRAM write,
  // pushes the reference word on every read grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_q.delete();
      wr_q.delete();
    end else begin
      if (refill_done) done_cnt++;
      if (rd_rvalid && rd_rready) begin
        if (rd_q.size() == 0) check_eq("rd_unexpected", DW'(1), DW'(0));
        else check_eq("rd_data", rd_rdata, rd_q.pop_front());
      end
      if (rd_gnt) begin
        check_eq("gnt_we", DW'(sram_we), DW'(0));
        check_eq("gnt_addr", DW'(sram_addr), DW'(rd_addr));
        rd_q.push_back(exp_mem[rd_addr]);
      end
      if (sram_req && sram_we) begin
        if (wr_q.size() == 0) check_eq("wr_unexpected", DW'(1), DW'(0));
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check_eq("wr_addr", DW'(sram_addr), DW'(w.addr));
          check_eq("wr_data", sram_wdata, w.data);
          check_eq("wr_be", DW'(sram_be), DW'({BEW{1'b1}}));
          check_eq("wr_ready", DW'(refill_ready), DW'(1));
          check_eq("wr_no_rd_gnt", DW'(rd_gnt), DW'(0));
          exp_mem[w.addr] = w.data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    refill_valid = 1'b1;
    refill_data  = d;
    wr_q.push_back('{addr: a, data: d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < NW; i++) begin
      sram_mem[i] = pat(i);
      exp_mem[i]  = pat(i);
    end
    sram_rdata   = '0;
    rst_n        = 1'b0;
    refill_req   = 1'b0;
    refill_line  = '0;
    refill_valid = 1'b0;
    refill_data  = '0;
    rd_req       = 1'b0;
    rd_addr      = '0;
    rd_rready    = 1'b1;

    smp();
    check_eq("rst_refill_gnt", DW'(refill_gnt), DW'(1));
    check_eq("rst_refill_ready", DW'(refill_ready), DW'(0));
    check_eq("rst_done", DW'(refill_done), DW'(0));
    check_eq("rst_rd_gnt", DW'(rd_gnt), DW'(0));
    check_eq("rst_rvalid", DW'(rd_rvalid), DW'(0));
    check_eq("rst_sram_req", DW'(sram_req), DW'(0));
    check_eq("rst_sram_we", DW'(sram_we), DW'(0));
    tick();
    rst_n = 1'b1;

    // Back-to-back reads of 5 and 6
    rd_req = 1'b1; rd_addr = AW'(5);
    smp(); check_eq("b2b_gnt0", DW'(rd_gnt), DW'(1)); check_eq("b2b_rv0", DW'(rd_rvalid), DW'(0));
    tick(); rd_addr = AW'(6);
    smp(); check_eq("b2b_gnt1", DW'(rd_gnt), DW'(1)); check_eq("b2b_rv1", DW'(rd_rvalid), DW'(1));
    check_eq("b2b_dA", rd_rdata, pat(5));
    tick(); rd_req = 1'b0;
    smp(); check_eq("b2b_rv2", DW'(rd_rvalid), DW'(1)); check_eq("b2b_dB", rd_rdata, pat(6));
    tick();
    smp(); check_eq("b2b_rv3", DW'(rd_rvalid), DW'(0));
    tick();

    // Back-pressure: A held for 3 cycles, second read blocked
    rd_req = 1'b1; rd_addr = AW'(5); rd_rready = 1'b0;
    smp(); check_eq("bp_gnt0", DW'(rd_gnt), DW'(1));
    tick(); rd_addr = AW'(6);
    for (int k = 0; k < 3; k++) begin
      smp();
      check_eq("bp_rv", DW'(rd_rvalid), DW'(1));
      check_eq("bp_data", rd_rdata, pat(5));
      check_eq("bp_gnt_blk", DW'(rd_gnt), DW'(0));
      tick();
    end
    rd_rready = 1'b1;
    smp(); check_eq("bp_dA", rd_rdata, pat(5)); check_eq("bp_gnt2", DW'(rd_gnt), DW'(1));
    tick(); rd_req = 1'b0;
    smp(); check_eq("bp_rv2", DW'(rd_rvalid), DW'(1)); check_eq("bp_dB", rd_rdata, pat(6));
    tick();
    smp(); check_eq("bp_rv_end", DW'(rd_rvalid), DW'(0));
    tick();

    // Refill line 3 with a gap between beats
    d0 = done_cnt;
    refill_req = 1'b1; refill_line = LIW'(3);
    smp(); check_eq("rf_gnt", DW'(refill_gnt), DW'(1));
    tick(); refill_req = 1'b0; beat(AW'(6), D_C);
    smp(); check_eq("rf_ready0", DW'(refill_ready), DW'(1)); check_eq("rf_gnt_busy", DW'(refill_gnt), DW'(0));
    tick(); refill_valid = 1'b0;
    smp(); check_eq("rf_gap_ready", DW'(refill_ready), DW'(0)); check_eq("rf_gap_req", DW'(sram_req), DW'(0));
    tick(); beat(AW'(7), D_D);
    smp(); check_eq("rf_ready1", DW'(refill_ready), DW'(1)); check_eq("rf_done_early", DW'(refill_done), DW'(0));
    tick(); refill_valid = 1'b0;
    smp(); check_eq("rf_done", DW'(refill_done), DW'(1)); check_eq("rf_gnt_done", DW'(refill_gnt), DW'(1));
    tick();
    rd_req = 1'b1; rd_addr = AW'(7);
    smp(); check_eq("rf_done_once", DW'(done_cnt - d0), DW'(1)); check_eq("rf_rd_gnt", DW'(rd_gnt), DW'(1));
    tick(); rd_req = 1'b0;
    smp(); check_eq("rf_rd_D", rd_rdata, D_D);
    tick();

    // Arbitration: refill beat beats a same-cycle read of addr 100
    refill_req = 1'b1; refill_line = LIW'(10);
    tick(); refill_req = 1'b0; beat(AW'(20), D_E); rd_req = 1'b1; rd_addr = AW'(100);
    smp(); check_eq("arb_we", DW'(sram_we), DW'(1)); check_eq("arb_no_gnt", DW'(rd_gnt), DW'(0));
    tick(); refill_valid = 1'b0;
    smp(); check_eq("arb_gnt_gap", DW'(rd_gnt), DW'(1));
    tick(); rd_req = 1'b0; beat(AW'(21), D_F);
    smp(); check_eq("arb_ready1", DW'(refill_ready), DW'(1));
    tick(); refill_valid = 1'b0;
    smp(); check_eq("arb_done", DW'(refill_done), DW'(1));
    tick();

    // Hazard: refill line 4; addr 9 stalls, addr 20 issues in a gap
    refill_req = 1'b1; refill_line = LIW'(4);
    tick(); refill_req = 1'b0; rd_req = 1'b1; rd_addr = AW'(9);
    smp(); check_eq("hz_stall0", DW'(rd_gnt), DW'(0));
    tick(); beat(AW'(8), D_G);
    smp(); check_eq("hz_stall1", DW'(rd_gnt), DW'(0));
    tick(); refill_valid = 1'b0; rd_addr = AW'(20);
    smp(); check_eq("hz_other_gnt", DW'(rd_gnt), DW'(1));
    tick(); rd_addr = AW'(9); beat(AW'(9), D_H);
    smp(); check_eq("hz_stall2", DW'(rd_gnt), DW'(0));
    tick(); refill_valid = 1'b0;
    smp(); check_eq("hz_gnt_idle", DW'(rd_gnt), DW'(1));
    tick(); rd_req = 1'b0;
    smp(); check_eq("hz_rv", DW'(rd_rvalid), DW'(1)); check_eq("hz_new_H", rd_rdata, D_H);
    tick();

    // Reset mid-refill with a read in flight
    refill_req = 1'b1; refill_line = LIW'(6);
    tick(); refill_req = 1'b0; beat(AW'(12), D_I);
    tick(); refill_valid = 1'b0; rd_req = 1'b1; rd_addr = AW'(40);
    smp(); check_eq("mr_gnt", DW'(rd_gnt), DW'(1));
    tick(); rst_n = 1'b0; rd_req = 1'b0;
    smp();
    check_eq("mr_refill_gnt", DW'(refill_gnt), DW'(1));
    check_eq("mr_rvalid", DW'(rd_rvalid), DW'(0));
    check_eq("mr_sram_req", DW'(sram_req), DW'(0));
    check_eq("mr_sram_we", DW'(sram_we), DW'(0));
    check_eq("mr_done", DW'(refill_done), DW'(0));
    tick(); tick(); rst_n = 1'b1;
    smp(); check_eq("mr_post_gnt", DW'(refill_gnt), DW'(1)); check_eq("mr_post_rv", DW'(rd_rvalid), DW'(0));
    tick(); rd_req = 1'b1; rd_addr = AW'(12);
    smp(); check_eq("mr_rd_gnt", DW'(rd_gnt), DW'(1));
    tick(); rd_req = 1'b0;
    smp(); check_eq("mr_no_rollback", rd_rdata, D_I);
    tick(); tick();
    smp();
    check_eq("rd_q_empty", DW'(rd_q.size()), DW'(0));
    check_eq("wr_q_empty", DW'(wr_q.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
